// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the BRAM port arbiter: FSM state encoding and
// the index-width helper used to size pointers and owner fields.
package bram_port_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: returns a one-hot grant for the first set
// request bit at or after the pointer, wrapping modulo NUM_REQ.
module rr_priority_picker
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant
);

  // scan from the pointer and keep only the first hit
  always_comb begin
    int   idx_s;
    logic found_s;
    grant   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = (int'(pointer) + k) % NUM_REQ;
      if (!found_s && request[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto one BRAM data port with round-robin
// fairness, a lock mode for atomic sequences, and a one-hot read-return tag.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int NUM_REQ      = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_read,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ-1:0]                 req_lock,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]    req_byte_en,
  input  logic [NUM_REQ*ADDRESS_BITS-1:0]    req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data_in,
  output logic [NUM_REQ-1:0]                 req_grant,
  output logic [NUM_REQ-1:0]                 req_valid,
  output logic [DATA_WIDTH-1:0]              req_data_out,
  output logic [ADDRESS_BITS-1:0]            req_address_out,
  output logic                               mem_read,
  output logic                               mem_write,
  output logic [DATA_WIDTH/8-1:0]            mem_byte_en,
  output logic [ADDRESS_BITS-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]              mem_data_in,
  input  logic [DATA_WIDTH-1:0]              mem_data_out,
  input  logic [ADDRESS_BITS-1:0]            mem_address_out,
  input  logic                               mem_valid,
  input  logic                               mem_ready
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t         state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   owner_r;
  logic [NUM_REQ-1:0] tag_r;

  logic [NUM_REQ-1:0] requesting_s;
  logic [NUM_REQ-1:0] eligible_s;
  logic [NUM_REQ-1:0] owner_onehot_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               grant_any_s;
  logic               grant_read_s;
  logic               grant_lock_s;
  logic               owner_lock_s;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
    if (v == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return v + IDX_W'(1);
    end
  endfunction

  assign requesting_s = req_read | req_write;

  // decode the lock owner into a mask
  always_comb begin
    owner_onehot_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_r == IDX_W'(i)) begin
        owner_onehot_s[i] = 1'b1;
      end else begin
        owner_onehot_s[i] = 1'b0;
      end
    end
  end

  // while locked only the owner may compete; no grants during reset or stall
  always_comb begin
    if (!reset || !mem_ready) begin
      eligible_s = '0;
    end else if (state_r == LOCKED) begin
      eligible_s = requesting_s & owner_onehot_s;
    end else begin
      eligible_s = requesting_s;
    end
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .request (eligible_s),
    .pointer (rr_ptr_r),
    .grant   (grant_s)
  );

  assign req_grant    = grant_s;
  assign grant_any_s  = |grant_s;
  assign grant_read_s = |(grant_s & req_read);
  assign grant_lock_s = |(grant_s & req_lock);
  assign owner_lock_s = |(req_lock & owner_onehot_s);

  // route the granted requester onto the memory port, zero when idle
  always_comb begin
    grant_idx_s = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_byte_en = '0;
    mem_address = '0;
    mem_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        grant_idx_s = IDX_W'(i);
        mem_read    = req_read[i];
        mem_write   = req_write[i];
        mem_byte_en = req_byte_en[i*BE_W +: BE_W];
        mem_address = req_address[i*ADDRESS_BITS +: ADDRESS_BITS];
        mem_data_in = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // arbitration FSM, round-robin pointer, lock owner and read tag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= ARB;
      rr_ptr_r <= '0;
      owner_r  <= '0;
      tag_r    <= '0;
    end else begin
      tag_r <= grant_read_s ? grant_s : '0;
      if (!mem_ready) begin
        state_r  <= state_r;
        rr_ptr_r <= rr_ptr_r;
        owner_r  <= owner_r;
      end else begin
        case (state_r)
          ARB: begin
            if (grant_any_s) begin
              rr_ptr_r <= inc_wrap(grant_idx_s);
              if (grant_lock_s) begin
                state_r <= LOCKED;
                owner_r <= grant_idx_s;
              end else begin
                state_r <= ARB;
              end
            end else begin
              state_r <= ARB;
            end
          end
          LOCKED: begin
            // releasing the lock hands priority to the requester after the owner
            if (!owner_lock_s) begin
              state_r  <= ARB;
              rr_ptr_r <= inc_wrap(owner_r);
            end else if (grant_any_s) begin
              rr_ptr_r <= inc_wrap(grant_idx_s);
            end else begin
              state_r <= LOCKED;
            end
          end
          default: begin
            state_r <= ARB;
          end
        endcase
      end
    end
  end

  assign req_valid       = tag_r & {NUM_REQ{mem_valid}};
  assign req_data_out    = mem_data_out;
  assign req_address_out = mem_address_out;

endmodule
